// File: rtl/debounce_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_pkg : shared constants and edge qualification for debounce_bank
// Rev 1.0
// ----------------------------------------------------------------------------
package debounce_pkg;

  localparam int EDGE_RISE     = 0;
  localparam int EDGE_FALL     = 1;
  localparam int EDGE_BOTH     = 2;
  localparam int DEFAULT_CNT_W = 4;

  // Decides whether a change of the filtered level to new_level earns a pulse.
  // Any mode value other than rise/fall is treated as "both".
  function automatic logic edge_qualify(input int mode, input logic new_level);
    logic ok;
    case (mode)
      EDGE_RISE: ok = new_level;
      EDGE_FALL: ok = ~new_level;
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_channel : one synchronised, tick-filtered input with edge and flag
// Rev 1.0
// ----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int EDGE_MODE = EDGE_BOTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_raw,
  input  logic             ce,
  input  logic [CNT_W-1:0] threshold,
  input  logic             evt_clr,
  output logic             out_level,
  output logic             out_edge,
  output logic             evt_flag,
  output logic [CNT_W-1:0] count
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             edge_q, edge_d;
  logic             flag_q, flag_d;

  always_comb begin
    sync1_d = in_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;

    // Agreement always wins and discards any partial count, ticking or not.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (ce) begin
      if (cnt_q == threshold) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    edge_d = (level_d != level_q) && edge_qualify(EDGE_MODE, level_d);
    // A fresh event outranks a concurrent clear so no event is ever lost.
    flag_d = edge_d ? 1'b1 : (evt_clr ? 1'b0 : flag_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
      flag_q  <= flag_d;
    end
  end

  assign out_level = level_q;
  assign out_edge  = edge_q;
  assign evt_flag  = flag_q;
  assign count     = cnt_q;

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_bank : NCH independent debounce channels sharing one tick/threshold
// Rev 1.0
// ----------------------------------------------------------------------------
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int EDGE_MODE = EDGE_BOTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_signal,
  input  logic                 ce,
  input  logic [CNT_W-1:0]     threshold,
  input  logic [NCH-1:0]       evt_clr,
  output logic [NCH-1:0]       out_signal,
  output logic [NCH-1:0]       out_edge,
  output logic [NCH-1:0]       evt_flag,
  output logic                 any_evt,
  output logic [NCH*CNT_W-1:0] q_count
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in_raw    (in_signal[i]),
      .ce        (ce),
      .threshold (threshold),
      .evt_clr   (evt_clr[i]),
      .out_level (out_signal[i]),
      .out_edge  (out_edge[i]),
      .evt_flag  (evt_flag[i]),
      .count     (q_count[i*CNT_W +: CNT_W])
    );
  end

  assign any_evt = |evt_flag;

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_debounce_bank : directed self-checking bench for debounce_bank
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_debounce_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_signal, evt_clr, in_r, evt_clr_r;
  logic        ce;
  logic [3:0]  threshold;
  logic [3:0]  out_signal, out_edge, evt_flag;
  logic [3:0]  out_r, edge_r, flag_r;
  logic        any_evt, any_r;
  logic [15:0] q_count, q_count_r;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_bank #(.NCH(4), .CNT_W(4), .EDGE_MODE(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_signal  (in_signal),
    .ce         (ce),
    .threshold  (threshold),
    .evt_clr    (evt_clr),
    .out_signal (out_signal),
    .out_edge   (out_edge),
    .evt_flag   (evt_flag),
    .any_evt    (any_evt),
    .q_count    (q_count)
  );

  // Rising-only build used for the edge qualification checks.
  debounce_bank #(.NCH(4), .CNT_W(4), .EDGE_MODE(0)) u_dut_r (
    .clk        (clk),
    .rst        (rst),
    .in_signal  (in_r),
    .ce         (ce),
    .threshold  (threshold),
    .evt_clr    (evt_clr_r),
    .out_signal (out_r),
    .out_edge   (edge_r),
    .evt_flag   (flag_r),
    .any_evt    (any_r),
    .q_count    (q_count_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_signal = '0;
    in_r      = '0;
    evt_clr   = '0;
    evt_clr_r = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_out, exp_edge;

    // Reset with all inputs held high; threshold 3, ce tied high.
    rst = 1'b1; in_signal = 4'hF; in_r = '0; evt_clr = '0; evt_clr_r = '0;
    ce = 1'b1; threshold = 4'd3;
    step();
    check("rst_out",   out_signal, 4'h0);
    check("rst_edge",  out_edge,   4'h0);
    check("rst_flag",  evt_flag,   4'h0);
    check("rst_any",   any_evt,    1'b0);
    check("rst_count", q_count,    16'h0000);
    step();
    rst = 1'b0;
    // First edge after release samples the high level (k); output at k+5.
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 5) begin
        check("req_out_pre",   out_signal, 4'h0);
        check("req_count_max", q_count,    16'h3333);
      end
      if (n == 6) begin
        check("req_out",   out_signal, 4'hF);
        check("req_edge",  out_edge,   4'hF);
        check("req_flag",  evt_flag,   4'hF);
        check("req_count", q_count,    16'h0000);
      end
      if (n == 7) begin
        check("req_edge_1cyc", out_edge, 4'h0);
        check("req_flag_hold", evt_flag, 4'hF);
        check("req_any",       any_evt,  1'b1);
      end
    end
    evt_clr = 4'hF;
    step();
    evt_clr = 4'h0;
    check("clr_all_flag", evt_flag, 4'h0);
    check("clr_all_any",  any_evt,  1'b0);

    // Glitch rejection on ch0: three clocks high is rejected.
    do_reset();
    threshold = 4'd3; ce = 1'b1;
    in_signal = 4'h1;
    step(); step(); step();
    in_signal = 4'h0;
    step();
    step();
    check("glitch_peak",     q_count[3:0], 4'd3);
    check("glitch_out_pre",  out_signal,   4'h0);
    step();
    check("glitch_cnt_zero", q_count[3:0], 4'd0);
    step(); step(); step(); step();
    check("glitch_out",  out_signal, 4'h0);
    check("glitch_edge", out_edge,   4'h0);
    // Four clocks high is accepted.
    in_signal = 4'h1;
    step(); step(); step(); step();
    in_signal = 4'h0;
    step();
    check("accept_out_pre", out_signal,   4'h0);
    check("accept_cnt3",    q_count[3:0], 4'd3);
    step();
    check("accept_out",  out_signal, 4'h1);
    check("accept_edge", out_edge,   4'h1);
    step();
    check("accept_edge_1cyc", out_edge, 4'h0);

    // Tick gating on ch1: ce every 4th clock, threshold 2.
    ce = 1'b0;
    do_reset();
    threshold = 4'd2;
    in_signal = 4'h2;
    for (int n = 1; n <= 12; n++) begin
      ce = (n % 4 == 0);
      step();
      if (n == 6)  check("tick_hold1", q_count[7:4], 4'd1);
      if (n == 11) begin
        check("tick_hold2",    q_count[7:4], 4'd2);
        check("tick_out_pre",  out_signal,   4'h0);
      end
      if (n == 12) begin
        check("tick_out",  out_signal, 4'h2);
        check("tick_edge", out_edge,   4'h2);
      end
    end
    ce = 1'b1;

    // Rising-only build: ch2 rises, then falls; threshold 1 -> output at k+3.
    do_reset();
    threshold = 4'd1;
    in_r = 4'h4;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 3) check("rise_out_pre", out_r, 4'h0);
      if (n == 4) begin
        check("rise_out",  out_r,  4'h4);
        check("rise_edge", edge_r, 4'h4);
      end
      if (n == 5) check("rise_edge_1cyc", edge_r, 4'h0);
    end
    in_r = 4'h0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 3) check("fall_out_pre", out_r, 4'h4);
      if (n == 4) begin
        check("fall_out",       out_r,  4'h0);
        check("fall_no_edge",   edge_r, 4'h0);
        check("fall_flag_kept", flag_r, 4'h4);
      end
    end

    // Sticky flag on ch3.
    do_reset();
    threshold = 4'd1;
    in_signal = 4'h8;
    step(); step(); step(); step();
    check("sticky_out",  out_signal, 4'h8);
    check("sticky_flag", evt_flag,   4'h8);
    check("sticky_any",  any_evt,    1'b1);
    step(); step();
    check("sticky_hold", evt_flag, 4'h8);
    evt_clr = 4'h8;
    step();
    evt_clr = 4'h0;
    check("sticky_clr",     evt_flag, 4'h0);
    check("sticky_clr_any", any_evt,  1'b0);
    evt_clr = 4'h8;
    step();
    evt_clr = 4'h0;
    check("sticky_clr_idle", evt_flag, 4'h0);
    in_signal = 4'h0;
    step(); step(); step();
    evt_clr = 4'h8;
    step();
    evt_clr = 4'h0;
    check("setclr_edge", out_edge,   4'h8);
    check("setclr_out",  out_signal, 4'h0);
    check("setclr_flag", evt_flag,   4'h8);
    step();
    check("setclr_flag_hold", evt_flag, 4'h8);
    check("setclr_edge_1cyc", out_edge, 4'h0);

    // Independence: staggered rises, threshold 0 -> each lands at its k+2.
    do_reset();
    threshold = 4'd0;
    for (int n = 1; n <= 8; n++) begin
      if (n <= 4) in_signal[n-1] = 1'b1;
      step();
      exp_out  = '0;
      exp_edge = '0;
      for (int i = 0; i < 4; i++) begin
        exp_out[i]  = (n >= i + 3);
        exp_edge[i] = (n == i + 3);
      end
      check($sformatf("indep_out_%0d", n),  out_signal, exp_out);
      check($sformatf("indep_edge_%0d", n), out_edge,   exp_edge);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
